// File: rtl/lfsr_descrambler_checker.sv
// Receive-side descrambler for the permuted 25-bit LFSR stream.
// Restores the raw LFSR word and tracks it with a local predictor.
module lfsr_descrambler_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_data,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] UNSYNC = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCK   = 2'd2;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    logic [1:0]  state;
    logic [24:0] pred;
    logic [3:0]  run;
    logic [3:0]  run_inc;
    logic [24:0] d;
    logic [24:0] d_next;
    logic        accept;
    logic        hit;
    logic        zero;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign d = {in_data[7],  in_data[21], in_data[15], in_data[1],
                in_data[0],  in_data[18], in_data[4],  in_data[24],
                in_data[20], in_data[2],  in_data[3],  in_data[11],
                in_data[13], in_data[23], in_data[10], in_data[12],
                in_data[17], in_data[22], in_data[5],  in_data[6],
                in_data[19], in_data[16], in_data[8],  in_data[14],
                in_data[9]};

    assign d_next  = {d[23:0], d[24] ^ d[21]};
    assign hit     = (d == pred);
    assign zero    = (d == 25'd0);
    assign run_inc = run + 4'd1;
    assign locked  = (state == LOCK);

    // One-entry output register, reloaded on every accept
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= 25'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Predictor FSM: seed, count consecutive hits, flag failures when locked
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= UNSYNC;
            pred      <= 25'd0;
            run       <= 4'd0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            mismatch <= 1'b0;
            if (accept) begin
                unique case (state)
                    UNSYNC: begin
                        if (!zero) begin
                            pred  <= d_next;
                            run   <= 4'd0;
                            state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (hit) begin
                            pred <= d_next;
                            run  <= run_inc;
                            if (run_inc == LOCK_N)
                                state <= LOCK;
                        end else if (!zero) begin
                            pred <= d_next;
                            run  <= 4'd0;
                        end else begin
                            state <= UNSYNC;
                        end
                    end
                    LOCK: begin
                        if (hit) begin
                            pred <= d_next;
                        end else begin
                            mismatch <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                            if (!zero) begin
                                pred  <= d_next;
                                run   <= 4'd0;
                                state <= TRACK;
                            end else begin
                                state <= UNSYNC;
                            end
                        end
                    end
                    default: state <= UNSYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_descrambler_checker.sv
// Bench for lfsr_descrambler_checker with a rule-level reference model.
// A second instance with a 2-bit error counter exercises saturation.
module tb_lfsr_descrambler_checker;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [24:0] out_data;
    logic [24:0] out_data2;
    logic        locked;
    logic        locked2;
    logic        mismatch;
    logic        mismatch2;
    logic [15:0] err_count;
    logic [1:0]  err_count2;

    lfsr_descrambler_checker #(.LOCK_COUNT(4), .ERR_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .locked(locked), .mismatch(mismatch), .err_count(err_count)
    );

    lfsr_descrambler_checker #(.LOCK_COUNT(4), .ERR_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .locked(locked2), .mismatch(mismatch2), .err_count(err_count2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    // raw bit i travels on scrambled bit perm[i]
    int perm [25] = '{9, 14, 8, 16, 19, 6, 5, 22, 17, 12, 10, 23, 13,
                      11, 3, 2, 20, 24, 4, 18, 0, 1, 15, 21, 7};

    // reference model state
    int          m_state;
    logic [24:0] m_pred;
    int          m_run;
    logic        m_ov;
    logic [24:0] m_od;
    logic        m_mis;
    int          m_err;
    logic        obs_ready;

    function automatic logic [24:0] scr(input logic [24:0] r);
        logic [24:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[perm[i]] = r[i];
        return s;
    endfunction

    function automatic logic [24:0] descr(input logic [24:0] s);
        logic [24:0] r;
        for (int i = 0; i < 25; i++) r[i] = s[perm[i]];
        return r;
    endfunction

    function automatic logic [24:0] nxt(input logic [24:0] x);
        return ((x << 1) | 25'(x[24] ^ x[21])) & 25'h1ffffff;
    endfunction

    function automatic int exp_err(input int width);
        int lim;
        lim = (1 << width) - 1;
        return (m_err > lim) ? lim : m_err;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pred = '0; m_run = 0;
        m_ov = 0; m_od = '0; m_mis = 0; m_err = 0;
    endtask

    task automatic model_word(input logic [24:0] d);
        if (m_state == 0) begin
            if (d != 0) begin
                m_pred = nxt(d); m_run = 0; m_state = 1;
            end
        end else if (d == m_pred) begin
            m_pred = nxt(d);
            if (m_state == 1) begin
                m_run++;
                if (m_run == 4) m_state = 2;
            end
        end else begin
            if (m_state == 2) begin
                m_mis = 1; m_err++;
            end
            if (d != 0) begin
                m_pred = nxt(d); m_run = 0; m_state = 1;
            end else begin
                m_state = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [24:0] data,
                        input logic rdy);
        bit acc;
        in_valid = v; in_data = data; out_ready = rdy;
        #1;
        obs_ready = in_ready;
        acc = v && (!m_ov || rdy);
        @(posedge Clk);
        #1;
        m_mis = 0;
        if (Reset) begin
            model_reset();
        end else if (acc) begin
            m_od = descr(data); m_ov = 1;
            model_word(m_od);
        end else if (rdy) begin
            m_ov = 0;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1'b0, '0, 1'b0);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 25'd0)
            $display("FAIL reset_out: valid=%b data=%h want 0/0",
                     out_valid, out_data);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 16'd0)
            $display("FAIL reset_status: lk=%b mm=%b err=%0d want 0",
                     locked, mismatch, err_count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_lock();
        int lk [5] = '{1, 2, 4, 8, 16};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, scr(25'(lk[i])), 1'b1);
            n_total++;
            if (out_data !== 25'(lk[i]) || out_valid !== 1'b1)
                $display("FAIL lock_data[%0d]: got %h/%b want %h/1",
                         i, out_data, out_valid, lk[i]);
            else n_pass++;
            n_total++;
            if (locked !== (i == 4) || mismatch !== 1'b0)
                $display("FAIL lock_state[%0d]: lk=%b mm=%b want %b/0",
                         i, locked, mismatch, i == 4);
            else n_pass++;
        end
    endtask

    task automatic test_mismatch();
        int rl [4] = '{2, 4, 8, 16};
        step(1'b1, 25'h0000200, 1'b1);
        n_total++;
        if (mismatch !== 1'b1 || err_count !== 16'd1 || locked !== 1'b0)
            $display("FAIL mm_pulse: mm=%b err=%0d lk=%b want 1/1/0",
                     mismatch, err_count, locked);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, scr(25'(rl[i])), 1'b1);
            n_total++;
            if (mismatch !== 1'b0 || locked !== (i == 3))
                $display("FAIL mm_relock[%0d]: mm=%b lk=%b want 0/%b",
                         i, mismatch, locked, i == 3);
            else n_pass++;
        end
        n_total++;
        if (err_count !== 16'd1)
            $display("FAIL mm_err_hold: got %0d want 1", err_count);
        else n_pass++;
    endtask

    task automatic test_zero();
        logic [24:0] x;
        do_reset();
        step(1'b1, 25'd0, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 25'd0 || locked !== 1'b0)
            $display("FAIL zero_fwd: v=%b d=%h lk=%b want 1/0/0",
                     out_valid, out_data, locked);
        else n_pass++;
        x = 25'd1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, scr(x), 1'b1);
            n_total++;
            if (out_data !== x || locked !== (i == 4))
                $display("FAIL zero_seed[%0d]: d=%h lk=%b want %h/%b",
                         i, out_data, locked, x, i == 4);
            else n_pass++;
            x = nxt(x);
        end
    endtask

    task automatic test_backpressure();
        logic [24:0] x;
        do_reset();
        x = 25'd5;
        step(1'b1, scr(x), 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)), 25'($urandom), 1'b0);
            n_total++;
            if (obs_ready !== 1'b0)
                $display("FAIL bp_ready[%0d]: got %b want 0", i, obs_ready);
            else n_pass++;
            n_total++;
            if (out_data !== x || out_valid !== 1'b1 || locked !== 1'b0)
                $display("FAIL bp_hold[%0d]: d=%h v=%b lk=%b want %h/1/0",
                         i, out_data, out_valid, locked, x);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            x = nxt(x);
            step(1'b1, scr(x), 1'b1);
            n_total++;
            if (obs_ready !== 1'b1 || out_data !== x)
                $display("FAIL bp_release[%0d]: rdy=%b d=%h want 1/%h",
                         i, obs_ready, out_data, x);
            else n_pass++;
            n_total++;
            if (locked !== (i == 3) || mismatch !== 1'b0)
                $display("FAIL bp_lock[%0d]: lk=%b mm=%b want %b/0",
                         i, locked, mismatch, i == 3);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int want2 [5] = '{1, 2, 3, 3, 3};
        logic [24:0] x;
        logic [24:0] bad;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            x = 25'($urandom) | 25'h1;
            for (int i = 0; i < 5; i++) begin
                step(1'b1, scr(x), 1'b1);
                x = nxt(x);
            end
            n_total++;
            if (locked2 !== 1'b1 || locked2 !== (m_state == 2))
                $display("FAIL sat_lock[%0d]: got %b want 1", r, locked2);
            else n_pass++;
            bad = m_pred ^ 25'h1000;
            step(1'b1, scr(bad), 1'b1);
            n_total++;
            if (err_count2 !== 2'(want2[r]) || mismatch2 !== 1'b1)
                $display("FAIL sat_err2[%0d]: err=%0d mm=%b want %0d/1",
                         r, err_count2, mismatch2, want2[r]);
            else n_pass++;
            n_total++;
            if (err_count !== 16'(r + 1))
                $display("FAIL sat_err16[%0d]: got %0d want %0d",
                         r, err_count, r + 1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [24:0] data;
        logic        v;
        logic        rdy;
        logic        er;
        int          r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 99);
            if (r < 6) data = 25'($urandom);
            else if (r < 9) data = 25'd0;
            else if (m_state == 0) data = scr(25'($urandom) | 25'h2);
            else data = scr(m_pred);
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            er  = !m_ov || rdy;
            step(v, data, rdy);
            n_total++;
            if (obs_ready !== er)
                $display("FAIL rnd_ready[%0d]: got %b want %b",
                         c, obs_ready, er);
            else n_pass++;
            n_total++;
            if (out_valid !== m_ov || (m_ov && out_data !== m_od))
                $display("FAIL rnd_out[%0d]: v=%b d=%h want %b/%h",
                         c, out_valid, out_data, m_ov, m_od);
            else n_pass++;
            n_total++;
            if (locked !== (m_state == 2) || mismatch !== m_mis)
                $display("FAIL rnd_stat[%0d]: lk=%b mm=%b want %b/%b",
                         c, locked, mismatch, m_state == 2, m_mis);
            else n_pass++;
            n_total++;
            if (err_count !== 16'(exp_err(16)) ||
                err_count2 !== 2'(exp_err(2)))
                $display("FAIL rnd_err[%0d]: e16=%0d e2=%0d want %0d/%0d",
                         c, err_count, err_count2, exp_err(16), exp_err(2));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] x;
        do_reset();
        x = 25'h0abcde;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, scr(x), 1'b0);
            step(1'b0, '0, 1'b1);
            x = nxt(x);
        end
        step(1'b1, scr(x ^ 25'h4), 1'b0);
        step(1'b0, '0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || err_count !== 16'd1)
            $display("FAIL rmid_pre: v=%b err=%0d want 1/1",
                     out_valid, err_count);
        else n_pass++;
        Reset = 1'b1;
        step(1'b1, scr(m_pred), 1'b1);
        Reset = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 25'd0 || in_ready !== 1'b1)
            $display("FAIL rmid_out: v=%b d=%h rdy=%b want 0/0/1",
                     out_valid, out_data, in_ready);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 16'd0)
            $display("FAIL rmid_stat: lk=%b mm=%b err=%0d want 0/0/0",
                     locked, mismatch, err_count);
        else n_pass++;
        x = 25'h3;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, scr(x), 1'b1);
            x = nxt(x);
        end
        n_total++;
        if (locked !== 1'b1)
            $display("FAIL rmid_relock: got %b want 1", locked);
        else n_pass++;
    endtask

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_lock();
        test_mismatch();
        test_zero();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
